eth_frame_recv: RTL

//   Byte-wide Ethernet receive framer; parametrised successor to the single-byte receive stage.

---
 rtl/eth_frame_recv_if.sv | 27 ++
 rtl/eth_frame_recv.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/eth_frame_recv_if.sv
// Byte-stream bus between the PHY-side receive path and the framer.
//
// Handshake: there is no backpressure. The PHY drives data/start every cycle.
// start=1 marks a valid input byte (preamble..last FCS byte). On the output
// side, vld=1 marks a valid frame byte on out, and sof/eof are qualifiers:
//   - sof is only meaningful together with vld;
//   - eof is a standalone pulse, never together with vld;
//   - len/err are qualified by eof.
// ready is advisory. It says that a frame starting now would be accepted.
interface eth_frame_recv_if #(
  parameter int LEN_W = 11
) ();
  logic [7:0]       data;
  logic             start;
  logic [7:0]       out;
  logic             vld;
  logic             sof;
  logic             eof;
  logic [LEN_W-1:0] len;
  logic             err;
  logic             ready;

  // PHY / source side
  modport master (output data, start, input out, vld, sof, eof, len, err, ready);
  // framer side
  modport slave  (input data, start, output out, vld, sof, eof, len, err, ready);
endinterface

// File: rtl/eth_frame_recv.sv
// Byte-wide Ethernet receive framer.
// It hunts for the preamble followed by the SFD, then streams DA..FCS bytes
// with sof/eof markers. At eof it reports the frame length and a length-error
// flag. A frame already in flight when reset is released is ignored. The
// framer only arms after it has seen start=0 once.
module eth_frame_recv #(
  parameter int         PREAMBLE_LEN = 7,
  parameter logic [7:0] PRE_BYTE     = 8'h55,
  parameter logic [7:0] SFD_BYTE     = 8'hD5,
  parameter int         MIN_LEN      = 64,
  parameter int         MAX_LEN      = 1518,
  parameter int         LEN_W        = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  eth_frame_recv_if.slave    bus,
  output logic [1:0]         dbg_state
);

  localparam int PCNT_W = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PCNT_W-1:0] PRE_MAX = PCNT_W'(PREAMBLE_LEN);
  localparam logic [LEN_W-1:0]  MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  MIN_L   = LEN_W'(MIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [PCNT_W-1:0] pcnt, pcnt_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  logic              armed, armed_n;
  logic [7:0]        out_q, out_n;
  logic              vld_q, vld_n;
  logic              sof_q, sof_n;
  logic              eof_q, eof_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic              err_q, err_n;
  logic              ready_q, ready_n;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pcnt    <= '0;
      cnt     <= '0;
      armed   <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      len_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      pcnt    <= pcnt_n;
      cnt     <= cnt_n;
      armed   <= armed_n;
      out_q   <= out_n;
      vld_q   <= vld_n;
      sof_q   <= sof_n;
      eof_q   <= eof_n;
      len_q   <= len_n;
      err_q   <= err_n;
      ready_q <= ready_n;
    end
  end

  // Next-state logic and next values of the registered outputs
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    cnt_n   = cnt;
    armed_n = armed | ~bus.start;
    out_n   = out_q;
    vld_n   = 1'b0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    len_n   = len_q;
    err_n   = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (armed && bus.data == PRE_BYTE) begin
            state_n = S_PREAMBLE;
            pcnt_n  = PCNT_W'(1);
          end else begin
            state_n = S_DROP;
          end
        end
      end

      S_PREAMBLE: begin
        if (!bus.start) begin
          state_n = S_IDLE;
        end else if (bus.data == PRE_BYTE) begin
          if (pcnt < PRE_MAX) pcnt_n = pcnt + PCNT_W'(1);
        end else if (bus.data == SFD_BYTE && pcnt >= PRE_MAX) begin
          state_n = S_PAYLOAD;
          cnt_n   = '0;
        end else begin
          state_n = S_DROP;
        end
      end

      S_PAYLOAD: begin
        if (!bus.start) begin
          // Carrier dropped: the frame ends here
          eof_n   = 1'b1;
          len_n   = cnt;
          err_n   = (cnt < MIN_L);
          state_n = S_IDLE;
        end else if (cnt < MAX_L) begin
          out_n = bus.data;
          vld_n = 1'b1;
          sof_n = (cnt == '0);
          cnt_n = cnt + LEN_W'(1);
        end else begin
          // Oversize frame: report it now and swallow the rest
          eof_n   = 1'b1;
          len_n   = MAX_L;
          err_n   = 1'b1;
          state_n = S_DROP;
        end
      end

      S_DROP: begin
        if (!bus.start) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase

    ready_n = (state_n == S_IDLE) && armed_n;
  end

  assign bus.out   = out_q;
  assign bus.vld   = vld_q;
  assign bus.sof   = sof_q;
  assign bus.eof   = eof_q;
  assign bus.len   = len_q;
  assign bus.err   = err_q;
  assign bus.ready = ready_q;
  assign dbg_state = state;

endmodule
